sisc_fetch: RTL
===============

# sisc_fetch

Instruction fetch unit for the SISC processor. It sits directly upstream of the control FSM and owns the program counter (PC) and the instruction register (IR). It fetches one instruction per request over a variable-latency instruction-memory handshake and presents `opcode`/`mm` to the controller. It also resolves branches (BRA/BRR/BNE/BNR) against `stat` when the controller strobes it.

## Interface
Parameters:
- `AW`, 16, PC / instruction-memory address width (≤ 16)
- `DW`, 32, instruction width
- `MAX_WAIT`, 15, maximum cycles `imem_req` may stay high without `imem_ack` before error

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst_f`  in  1  reset, asynchronous, active-high (1 = reset)
- `fetch_go`  in  1  pulse from controller: fetch instruction at current PC
- `br_eval`  in  1  pulse from controller: evaluate branch for instruction in IR
- `stat`  in  4  status flags from status register
- `imem_req`  out  1  instruction-memory request
- `imem_addr`  out  AW  address; equals PC while `imem_req`=1
- `imem_ack`  in  1  memory acknowledge; `imem_rdata` valid in same cycle
- `imem_rdata`  in  DW  instruction data
- `ir`  out  DW  instruction register
- `opcode`  out  4  `ir[31:28]`
- `mm`  out  4  `ir[27:24]`
- `ir_valid`  out  1  IR holds a freshly fetched instruction
- `pc`  out  AW  current PC
- `busy`  out  1  fetch in progress (state ≠ IDLE)
- `fetch_err`  out  1  sticky timeout error

## Operation
- States: IDLE, REQ, ERR.
- IDLE → REQ on `fetch_go`. `ir_valid` clears on the same edge.
- REQ: `imem_req`=1 with `imem_addr`=PC held stable.
  - On an edge with `imem_ack`=1: IR ← `imem_rdata`, PC ← PC+1 (mod 2^AW), `ir_valid` ← 1, → IDLE.
  - Otherwise the wait counter increments. When the counter reaches `MAX_WAIT`: `imem_req` ← 0, `fetch_err` ← 1, → ERR.
- ERR: terminal until reset. `fetch_go` and `br_eval` are ignored; IR, PC and `ir_valid` hold.
- `imem_ack` while `imem_req`=0 is ignored.
- `fetch_go` while busy is ignored, with no queueing.
- `br_eval` is honoured only in IDLE with `ir_valid`=1; it is ignored otherwise.
  - Condition `hit` = |(`stat` & `mm`).
  - BRA (4): if `hit`, PC ← `ir[15:0]` truncated to AW.
  - BRR (5): if `hit`, PC ← PC + sign-extended `ir[15:0]`, mod 2^AW. PC already points to the next instruction.
  - BNE (6): taken if !`hit`; target as BRA.
  - BNR (7): taken if !`hit`; target as BRR.
  - Any other opcode: no effect.
  - `br_eval` does not clear `ir_valid`.
- Simultaneous `fetch_go` and `br_eval` in IDLE: the branch is applied first. REQ then presents the branch target on `imem_addr`.
- `opcode` = 15 (HLT) has no special effect here; halting is the controller's concern.

## Timing
- Reset values: PC=0, IR=0, `ir_valid`=0, `imem_req`=0, `busy`=0, `fetch_err`=0, state=IDLE, wait counter=0.
- Reset is applied asynchronously. Reset mid-fetch drops `imem_req` immediately, without waiting for a clock edge.
- `fetch_go` sampled at edge N → `imem_req`=1 from edge N.
- With ack in the first REQ cycle, IR/`ir_valid` update at edge N+1. Minimum latency is 1 cycle from the `fetch_go` edge to `ir_valid`.
- Ack after k wait cycles → `ir_valid` at edge N+1+k.
- Timeout fires on the edge completing `MAX_WAIT` cycles of `imem_req` without ack. An ack arriving on that same edge wins: normal capture, no error.
- `br_eval` takes effect on the sampling edge; the new PC is visible the next cycle.
- All outputs are registered, except `opcode`/`mm` (wires from IR) and `imem_addr` (= PC).

## Structure
- Shared package `sisc_pkg` holds:
  - opcode constants (NOOP…HLT, identical to the controller's encodings);
  - IR field positions (opcode 31:28, mm 27:24, imm 15:0);
  - the fetch state enum.
- Sub-module `sisc_branch_unit`: combinational. Inputs are `opcode`, `mm`, `stat`, PC and imm; outputs are `taken` and `target`. It is reusable by a later pipelined variant.
- PC, IR, wait counter and FSM live in `sisc_fetch`.

## Test plan
- Reset, then `fetch_go` with a zero-latency memory returning 0x1800_0003 → `imem_addr`=0; next cycle `ir`=0x18000003, `opcode`=1, `mm`=8, `ir_valid`=1, `pc`=1.
- Memory with 3-cycle ack delay → `imem_req` high 4 cycles with `imem_addr` stable; `ir_valid` rises at edge N+4; extra `fetch_go` pulses during wait have no effect.
- IR=0x4200_0020 (BRA, mm=2), `stat`=2, `br_eval` → `pc`=0x20. Repeat with `stat`=1 → `pc` unchanged.
- PC=0x0005, IR=0x7100_FFFC (BNR, mm=1), `stat`=0, `br_eval`+`fetch_go` same cycle → `imem_addr`=0x0001 on the first REQ cycle.
- No ack for 15 cycles → `imem_req` drops, `fetch_err`=1, later `fetch_go` ignored; `rst_f` pulse → all outputs return to reset values.
- Assert `rst_f` mid-REQ between clock edges → `imem_req` falls before the next edge; `pc`=0, `ir_valid`=0.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode encodings, IR field positions and fetch FSM states.
package sisc_pkg;

    localparam logic [3:0] OP_NOOP = 4'd0;
    localparam logic [3:0] OP_REG  = 4'd1;
    localparam logic [3:0] OP_LOD  = 4'd2;
    localparam logic [3:0] OP_STR  = 4'd3;
    localparam logic [3:0] OP_BRA  = 4'd4;
    localparam logic [3:0] OP_BRR  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BNR  = 4'd7;
    localparam logic [3:0] OP_HLT  = 4'd15;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 28;
    localparam int unsigned MM_MSB  = 27;
    localparam int unsigned MM_LSB  = 24;
    localparam int unsigned IMM_MSB = 15;
    localparam int unsigned IMM_LSB = 0;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_ERR  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sisc_branch_unit.sv
// Combinational branch resolver: decides taken/target for BRA/BRR/BNE/BNR.
module sisc_branch_unit
    import sisc_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic [3:0]    opcode,
    input  logic [3:0]    mm,
    input  logic [3:0]    stat,
    input  logic [AW-1:0] pc,
    input  logic [15:0]   imm,
    output logic          taken,
    output logic [AW-1:0] target
);

    logic          hit;
    logic [AW-1:0] abs_target;
    logic [31:0]   rel_sum;
    logic [AW-1:0] rel_target;

    assign hit        = |(stat & mm);
    assign abs_target = imm[AW-1:0];
    // Relative target: PC already points past the branch; wraps mod 2^AW.
    assign rel_sum    = {{(32-AW){1'b0}}, pc} + {{16{imm[15]}}, imm};
    assign rel_target = rel_sum[AW-1:0];

    always_comb begin
        taken  = 1'b0;
        target = pc;
        case (opcode)
            OP_BRA: begin taken = hit;  target = abs_target; end
            OP_BRR: begin taken = hit;  target = rel_target; end
            OP_BNE: begin taken = !hit; target = abs_target; end
            OP_BNR: begin taken = !hit; target = rel_target; end
            default: begin taken = 1'b0; target = pc; end
        endcase
    end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch unit: owns PC and IR, fetches over a variable-latency
// req/ack handshake with a timeout, and applies branches on controller request.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          fetch_go,
    input  logic          br_eval,
    input  logic [3:0]    stat,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] ir,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic          ir_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          fetch_err
);

    localparam int unsigned    CW        = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(MAX_WAIT - 1);

    fetch_state_t  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          imem_req_q, imem_req_d;
    logic          busy_q, busy_d;
    logic          fetch_err_q, fetch_err_d;
    logic [CW-1:0] wait_q, wait_d;

    logic          br_taken;
    logic [AW-1:0] br_target;

    sisc_branch_unit #(
        .AW (AW)
    ) u_branch (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .pc     (pc_q),
        .imm    (ir_q[IMM_MSB:IMM_LSB]),
        .taken  (br_taken),
        .target (br_target)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        imem_req_d  = imem_req_q;
        busy_d      = busy_q;
        fetch_err_d = fetch_err_q;
        wait_d      = wait_q;
        case (state_q)
            FETCH_IDLE: begin
                // Branch lands in pc_d first so a same-cycle fetch uses the target.
                if (br_eval && ir_valid_q && br_taken) begin
                    pc_d = br_target;
                end
                if (fetch_go) begin
                    state_d    = FETCH_REQ;
                    imem_req_d = 1'b1;
                    busy_d     = 1'b1;
                    ir_valid_d = 1'b0;
                    wait_d     = '0;
                end
            end
            FETCH_REQ: begin
                if (imem_ack) begin
                    ir_d       = imem_rdata;
                    pc_d       = pc_q + AW'(1);
                    ir_valid_d = 1'b1;
                    imem_req_d = 1'b0;
                    busy_d     = 1'b0;
                    wait_d     = '0;
                    state_d    = FETCH_IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                    if (wait_q == WAIT_LAST) begin
                        imem_req_d  = 1'b0;
                        fetch_err_d = 1'b1;
                        state_d     = FETCH_ERR;
                    end
                end
            end
            FETCH_ERR: begin
                state_d = FETCH_ERR;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            imem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            fetch_err_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            imem_req_q  <= imem_req_d;
            busy_q      <= busy_d;
            fetch_err_q <= fetch_err_d;
            wait_q      <= wait_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign ir        = ir_q;
    assign opcode    = ir_q[OPC_MSB:OPC_LSB];
    assign mm        = ir_q[MM_MSB:MM_LSB];
    assign ir_valid  = ir_valid_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign fetch_err = fetch_err_q;

endmodule
